// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC update scheduler.
// The frame command nibble depends on the DAC_LDAC_EN macro (see dac_update_scheduler).
package dac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        LDAC  = 3'd5
    } sched_state_t;

    localparam logic [3:0] CMD_WR_UPD = 4'b0011;
    localparam logic [3:0] CMD_WR     = 4'b0000;
    localparam int         FRAME_W    = 24;
    localparam int         NUM_CH     = 4;

    // A DAC write frame is {command, 2'b00, channel, data}.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [3:0]  cmd,
        input logic [1:0]  ch,
        input logic [15:0] data
    );
        return {cmd, 2'b00, ch, data};
    endfunction

endpackage

// File: rtl/dac_update_scheduler_arbiter.sv
// Four-way round-robin arbiter, purely combinational.
// Search starts at the channel after 'last' and wraps around.
module rr_arbiter4
    import dac_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = last + 2'(i + 1);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Serialises four channel update requests onto one shared SPI DAC.
// Pending flags latch the strobes; a round-robin arbiter picks one channel
// from IDLE and the FSM shifts a 24-bit write frame out MSB first.
// Optional macro DAC_LDAC_EN: write-input-register command plus an LDAC
// pulse once the pending queue has drained.
module dac_update_scheduler
    import dac_sched_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  upd_req,
    input  logic [63:0] upd_value,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic [3:0]  pending,
    output logic [1:0]  active_ch,
    output logic        frame_done
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST  = 5'(FRAME_W - 1);
    localparam logic [3:0] PEND_INIT = (INIT_ON_RESET != 0) ? 4'hF : 4'h0;
`ifdef DAC_LDAC_EN
    localparam logic [3:0] FRAME_CMD = CMD_WR;
`else
    localparam logic [3:0] FRAME_CMD = CMD_WR_UPD;
`endif

    sched_state_t       state;
    logic [7:0]         div_cnt;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-2:0] shreg;
    logic [1:0]         last_ch;

    logic               gnt_valid;
    logic [1:0]         gnt_idx;
    logic               grant;
    logic [3:0]         grant_mask;
    logic [15:0]        gnt_data;
    logic [FRAME_W-1:0] gnt_frame;
    logic               div_last;

    rr_arbiter4 u_arb (
        .req       (pending),
        .last      (last_ch),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign grant     = (state == IDLE) && gnt_valid;
    assign div_last  = (div_cnt == DIV_LAST);
    assign gnt_data  = upd_value[{gnt_idx, 4'b0000} +: 16];
    assign gnt_frame = build_frame(FRAME_CMD, gnt_idx, gnt_data);

    // One-hot mask of the channel being granted this cycle (zero otherwise).
    always_comb begin
        grant_mask = 4'h0;
        if (grant) begin
            grant_mask[gnt_idx] = 1'b1;
        end
    end

    // Pending flags: cleared on grant, but a same-cycle strobe re-arms the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= PEND_INIT;
        end else begin
            pending <= (pending & ~grant_mask) | upd_req;
        end
    end

    // Frame sequencer: every output is registered and updated with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            shreg      <= '0;
            last_ch    <= 2'd3;
            active_ch  <= 2'd0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_sdi    <= 1'b0;
            dac_ldac_n <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= SETUP;
                        div_cnt   <= 8'd0;
                        bit_cnt   <= 5'd0;
                        shreg     <= gnt_frame[FRAME_W-2:0];
                        last_ch   <= gnt_idx;
                        active_ch <= gnt_idx;
                        dac_cs_n  <= 1'b0;
                        dac_sclk  <= 1'b0;
                        dac_sdi   <= gnt_frame[FRAME_W-1];
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        state   <= SHIFT;
                        div_cnt <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            dac_sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                dac_sdi <= shreg[FRAME_W-2];
                                shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        state      <= GAP;
                        div_cnt    <= 8'd0;
                        dac_cs_n   <= 1'b1;
                        dac_sdi    <= 1'b0;
                        frame_done <= (DIV_LAST == 8'd0);
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
`ifdef DAC_LDAC_EN
                        if (pending == 4'h0) begin
                            state      <= LDAC;
                            dac_ldac_n <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        div_cnt    <= div_cnt + 8'd1;
                        frame_done <= ((div_cnt + 8'd1) == DIV_LAST);
                    end
                end
                LDAC: begin
                    if (div_last) begin
                        div_cnt    <= 8'd0;
                        dac_ldac_n <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dac_cs_n <= 1'b1;
                    dac_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dac_update_scheduler.md
# dac_update_scheduler

Serialises the four gain/current-limit update requests from the I2C register block onto a single shared SPI DAC. The four requesters are DDS gain, CW gain, DDS current limit and CW current limit. Each `*_update` strobe is latched as a pending request. A round-robin arbiter picks one request at a time and transmits it as a 24-bit DAC write frame. The block sits between the register file and the DAC pins, and it also replays all four channels after reset so the DAC matches the register defaults.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 1..255.
- `INIT_ON_RESET`, default 1: when 1, all four channels are pending out of reset.

Ports:
- `clk` in 1: system clock; the block has one clock.
- `rst` in 1: reset, synchronous, active-high.
- `upd_req` in 4: one-cycle update strobes.
  - bit 0 = dds_gain, 1 = cw_gain, 2 = dds_current_limit, 3 = cw_current_limit.
- `upd_value` in 64: live register values, 16 bits per channel.
  - Channel n is `upd_value[16n+15:16n]`.
- `dac_cs_n` out 1: DAC chip select, active low.
- `dac_sclk` out 1: DAC serial clock; idles low.
- `dac_sdi` out 1: DAC serial data, MSB first.
- `dac_ldac_n` out 1: DAC load strobe, active low. Used only with the macro in Configuration.
- `busy` out 1: high whenever a frame is in progress (state is not IDLE).
- `pending` out 4: per-channel pending flags.
- `active_ch` out 2: channel currently being sent; holds its last value when IDLE.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
Pending flags:
- `upd_req[n]` sets `pending[n]`.
- A repeat request while `pending[n]` is already set coalesces into the single pending flag.
- `pending[n]` clears in the cycle channel n is granted.
- A request arriving in the grant cycle, or at any point during channel n's own frame, sets `pending[n]` again, so channel n is re-sent.

Grant:
- Grant happens only from IDLE, and only when `pending` is non-zero.
- Channel choice is round-robin, starting from the channel after `last_ch`.
- `last_ch` resets to 3, so channel 0 wins first.
- On grant, `upd_value` for the chosen channel is captured into a 24-bit shift register.
- Data sent is therefore the newest value at grant time, not the value at request time.

Frame format:
- Bits [23:20]: command, 4'b0011 (write and update).
- Bits [19:16]: {2'b00, channel}.
- Bits [15:0]: data.

State machine:
- IDLE: `cs_n` = 1, `sclk` = 0.
  - If any channel is pending → SETUP.
- SETUP: CLK_DIV cycles with `cs_n` = 0, `sclk` = 0, `sdi` = bit 23.
  - → SHIFT.
- SHIFT: 24 bits, each occupying 2·CLK_DIV cycles.
  - `sclk` is low for the first CLK_DIV cycles of a bit and high for the second CLK_DIV.
  - `sdi` changes only at falling edges of `sclk`.
  - After bit 0's high phase → HOLD.
- HOLD: CLK_DIV cycles with `cs_n` = 0, `sclk` = 0.
  - → GAP.
- GAP: CLK_DIV cycles with `cs_n` = 1.
  - `frame_done` pulses on the last GAP cycle.
  - → IDLE.

Boundary conditions:
- Requests are never dropped while a frame is in flight.
- The bit counter is 5 bits wide. The divider counter is 8 bits wide and wraps to 0 at CLK_DIV-1.
- Reset mid-frame: on the next edge `cs_n` = 1 and `sclk` = 0, and the state returns to IDLE. The aborted channel is handled by the reset value of `pending`.

## Timing
- Reset values of the outputs:
  - `dac_cs_n` = 1, `dac_sclk` = 0, `dac_sdi` = 0, `dac_ldac_n` = 1.
  - `busy` = 0, `active_ch` = 0, `frame_done` = 0.
  - `pending` = 4'hF if INIT_ON_RESET = 1, else 4'h0.
- A strobe in cycle t is visible in `pending` at t+1.
- Grant and the IDLE→SETUP transition happen at t+1 → t+2 from IDLE. `cs_n` is low in cycle t+2.
- Frame length is 51·CLK_DIV cycles from the first `cs_n`-low cycle to the `frame_done` cycle inclusive.
  - With CLK_DIV = 4 this is 204 cycles.
- Back-to-back frames: the next SETUP starts the cycle after IDLE is entered, so IDLE lasts exactly one cycle.
- All outputs are registered.

## Configuration
- `DAC_LDAC_EN` defined:
  - Command field becomes 4'b0000 (write input register only).
  - After a frame ends with `pending` = 0, `dac_ldac_n` is driven low for CLK_DIV cycles starting the cycle after `frame_done`.
  - `busy` stays high during that pulse.
  - New grants wait until the pulse finishes.
- `DAC_LDAC_EN` undefined:
  - Command is 4'b0011.
  - `dac_ldac_n` is constant 1.

## Structure
Shared package/include `dac_sched_pkg`:
- State encodings: IDLE, SETUP, SHIFT, HOLD, GAP, LDAC.
- Constants: CMD_WR_UPD = 4'b0011, CMD_WR = 4'b0000, FRAME_W = 24, NUM_CH = 4.

Sub-module `rr_arbiter4`:
- Inputs: `req[3:0]` and `last[1:0]`.
- Outputs: `gnt_valid` and `gnt_idx[1:0]`; purely combinational.

## Test plan
- Reset with INIT_ON_RESET = 1, CLK_DIV = 2, `upd_value` = {16'h523d, 16'h3dae, 16'h0000, 16'h0000} → four frames in order ch0, 1, 2, 3, each 102 cycles; ch2 frame bits = 24'h323dae.
- From idle, one strobe on `upd_req[1]` with ch1 = 16'h1234 → `cs_n` low 2 cycles later; 24 SCLK rising edges sample 24'h311234; one `frame_done` pulse.
- Strobe ch0 and ch3 in the same cycle after `last_ch` = 0 → ch3 is sent first, then ch0.
- Strobe ch2 three times during ch1's frame, changing the value to 16'hBEEF before grant → exactly one ch2 frame, carrying 16'hBEEF.
- Assert `rst` during SHIFT bit 10 → next cycle `cs_n` = 1, `sclk` = 0, `busy` = 0, `pending` = 4'hF.
- With `DAC_LDAC_EN` defined, CLK_DIV = 4 and a single ch0 request → command nibble 0, then `ldac_n` low for 4 cycles after `frame_done`.
